rstn_seq_sync: RTL and testbench

RSTN_SEQ_SYNC -- requirements
Module: rstn_seq_sync

---
 rtl/rstn_seq_pkg.sv | 23 ++
 rtl/rstn_sync_chain.sv | 25 ++
 rtl/rstn_seq_sync.sv | 146 ++++++++++++++
 tb/tb_rstn_seq_sync.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rstn_seq_pkg.sv
// Shared types and sizing helpers for the sequenced reset synchronizer.
// Holds the sequencer state encoding and the hold/gap counter width function.
package rstn_seq_pkg;

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } rst_state_e;

   // Width needed to hold the larger of the hold and gap spans without wrapping.
   function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
      int span;
      if (hold_cycles > gap_cycles) begin
         span = hold_cycles;
      end else begin
         span = gap_cycles;
      end
      return $clog2(span + 1);
   endfunction

endpackage

// File: rtl/rstn_sync_chain.sv
// Reset synchronizer shift chain: cleared asynchronously, shifts d_i in on every clk edge.
// All stages are exposed so the sequencer can see the capture edge of the last stage.
module rstn_sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   d_i,
   output logic [SYNC_STAGES-1:0] q_o
);

   logic [SYNC_STAGES-1:0] q_q;

   // Shift register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= {q_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/rstn_seq_sync.sv
// Sequenced reset generator: synchronizes rst_n, holds all channels, then releases
// them one by one in ascending order; soft_rst_req restarts the hold phase.
module rstn_seq_sync
   import rstn_seq_pkg::*;
#(
   parameter int CH_NUM      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              soft_rst_req,
   output logic [CH_NUM-1:0] sync_rst_n,
   output logic              all_released,
   output logic              busy
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam int IDX_W = $clog2(CH_NUM + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CH_NUM - 1);

   rst_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CH_NUM-1:0]      ch_q, ch_d;
   logic                   all_rel_q, all_rel_d;
   logic                   busy_q, busy_d;
   logic [SYNC_STAGES-1:0] sync_s;
   logic [IDX_W-1:0]       rel_idx_s;
   logic [CH_NUM-1:0]      rel_mask_s;

   rstn_sync_chain #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_chain (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (1'b1),
      .q_o   (sync_s)
   );

   // idx_q is the last channel released; the next one to go is idx_q + 1.
   assign rel_idx_s = idx_q + 1'b1;

   // One-hot mask of the channel due for release.
   always_comb begin
      rel_mask_s = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (IDX_W'(i) == rel_idx_s) begin
            rel_mask_s[i] = 1'b1;
         end else begin
            rel_mask_s[i] = 1'b0;
         end
      end
   end

   // Next-state, counter and channel-register logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      ch_d    = ch_q;
      if (soft_rst_req && (state_q != ST_SYNC)) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         ch_d    = '0;
      end else begin
         case (state_q)
            ST_SYNC: begin
               // Leave on the edge where the final stage captures the 1.
               if (sync_s[SYNC_STAGES-2] || sync_s[SYNC_STAGES-1]) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_SYNC;
               end
            end
            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  ch_d[0] = 1'b1;
                  if (CH_NUM == 1) begin
                     state_d = ST_RUN;
                  end else begin
                     state_d = ST_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d = '0;
                  ch_d  = ch_q | rel_mask_s;
                  if (rel_idx_s == LAST_IDX) begin
                     state_d = ST_RUN;
                     idx_d   = '0;
                  end else begin
                     idx_d = rel_idx_s;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_SYNC;
               cnt_d   = '0;
               idx_d   = '0;
               ch_d    = '0;
            end
         endcase
      end
      busy_d    = (state_d != ST_RUN);
      all_rel_d = (state_d == ST_RUN);
   end

   // State, counters and registered outputs; rst_n forces every channel low at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_SYNC;
         cnt_q     <= '0;
         idx_q     <= '0;
         ch_q      <= '0;
         all_rel_q <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         ch_q      <= ch_d;
         all_rel_q <= all_rel_d;
         busy_q    <= busy_d;
      end
   end

   assign sync_rst_n   = ch_q;
   assign all_released = all_rel_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_rstn_seq_sync.sv
// Bench for rstn_seq_sync: an edge-count model predicts every channel on every cycle,
// backed by literal expectations at the key edges of each scenario.
module tb_rstn_seq_sync;

   logic       clk;
   logic       rst_n;
   logic       soft_a;
   logic       soft_b;
   logic [3:0] ch_a;
   logic       allrel_a;
   logic       busy_a;
   logic [0:0] ch_b;
   logic       allrel_b;
   logic       busy_b;

   int vec_cnt;
   int err_cnt;
   int n_e;
   int base_a;
   logic [15:0] ea;
   logic [15:0] eb;

   rstn_seq_sync u_dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .soft_rst_req (soft_a),
      .sync_rst_n   (ch_a),
      .all_released (allrel_a),
      .busy         (busy_a)
   );

   rstn_seq_sync #(
      .CH_NUM      (1),
      .SYNC_STAGES (3),
      .HOLD_CYCLES (1),
      .GAP_CYCLES  (8)
   ) u_dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .soft_rst_req (soft_b),
      .sync_rst_n   (ch_b),
      .all_released (allrel_b),
      .busy         (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Channel k is released once the edge count reaches base + hold + k*gap.
   function automatic logic [15:0] exp_ch(input int n, input int base, input int h,
                                          input int g, input int ch);
      logic [15:0] r;
      r = '0;
      for (int k = 0; k < ch; k++) begin
         if (n >= base + h + k * g) r[k] = 1'b1;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at edge E%0d", name, act, exp, n_e);
      end
   endtask

   task automatic run_to(input int k);
      int guard;
      guard = 0;
      while (n_e < k && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (n_e != k) begin
         err_cnt++;
         $display("FAIL edge_reach: got E%0d expected E%0d", n_e, k);
      end
   endtask

   // Edge counter since rst_n rose and the reference edge for channel 0 of the main DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_e    <= 0;
         base_a <= 2;
      end else begin
         n_e <= n_e + 1;
         if (soft_a && (n_e + 1) > 2) base_a <= n_e + 1;
      end
   end

   // Cycle-by-cycle comparison of both DUTs against the model.
   always @(negedge clk) begin
      ea = exp_ch(n_e, base_a, 16, 8, 4);
      eb = exp_ch(n_e, 3, 1, 8, 1);
      chk("model_ch_a", 32'(ch_a), 32'(ea[3:0]));
      chk("model_allrel_a", 32'(allrel_a), 32'(ea[3:0] == 4'hF));
      chk("model_busy_a", 32'(busy_a), 32'(ea[3:0] != 4'hF));
      chk("model_ch_b", 32'(ch_b), 32'(eb[0]));
      chk("model_allrel_b", 32'(allrel_b), 32'(eb[0]));
      chk("model_busy_b", 32'(busy_b), 32'(!eb[0]));
   end

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      rst_n   = 1'b0;
      soft_a  = 1'b0;
      soft_b  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ch_a", 32'(ch_a), 32'h0);
      chk("rst_busy_a", 32'(busy_a), 32'h1);
      chk("rst_allrel_a", 32'(allrel_a), 32'h0);

      // Power-up sequence with soft_rst_req held through SYNC (must be ignored).
      soft_a = 1'b1;
      rst_n  = 1'b1;
      run_to(2);
      soft_a = 1'b0;
      run_to(3);
      chk("b_e3_ch", 32'(ch_b), 32'h0);
      run_to(4);
      chk("b_e4_ch", 32'(ch_b), 32'h1);
      chk("b_e4_allrel", 32'(allrel_b), 32'h1);
      run_to(17);
      chk("pwr_e17", 32'(ch_a), 32'h0);
      run_to(18);
      chk("pwr_e18", 32'(ch_a), 32'h1);
      run_to(26);
      chk("pwr_e26", 32'(ch_a), 32'h3);
      run_to(34);
      chk("pwr_e34", 32'(ch_a), 32'h7);
      run_to(41);
      chk("pwr_e41_busy", 32'(busy_a), 32'h1);
      run_to(42);
      chk("pwr_e42", 32'(ch_a), 32'hF);
      chk("pwr_e42_allrel", 32'(allrel_a), 32'h1);
      chk("pwr_e42_busy", 32'(busy_a), 32'h0);

      // Soft reset in RUN, held for three sampled edges E51..E53.
      run_to(50);
      soft_a = 1'b1;
      run_to(51);
      chk("soft_e51_ch", 32'(ch_a), 32'h0);
      chk("soft_e51_busy", 32'(busy_a), 32'h1);
      chk("soft_e51_allrel", 32'(allrel_a), 32'h0);
      run_to(53);
      soft_a = 1'b0;
      run_to(68);
      chk("soft_e68", 32'(ch_a), 32'h0);
      run_to(69);
      chk("soft_e69", 32'(ch_a), 32'h1);
      run_to(77);
      chk("soft_e77", 32'(ch_a), 32'h3);
      run_to(85);
      chk("soft_e85", 32'(ch_a), 32'h7);
      run_to(93);
      chk("soft_e93", 32'(ch_a), 32'hF);

      // Fresh power-up, then a one-cycle soft pulse at E30 aborts RELEASE.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_to(29);
      chk("abort_e29", 32'(ch_a), 32'h3);
      soft_a = 1'b1;
      run_to(30);
      chk("abort_e30", 32'(ch_a), 32'h0);
      soft_a = 1'b0;
      run_to(45);
      chk("abort_e45", 32'(ch_a), 32'h0);
      run_to(46);
      chk("abort_e46", 32'(ch_a), 32'h1);
      run_to(54);
      chk("abort_e54", 32'(ch_a), 32'h3);

      // 1 ns rst_n glitch between clock edges during RELEASE.
      run_to(60);
      #1;
      rst_n = 1'b0;
      #1;
      chk("glitch_ch_a", 32'(ch_a), 32'h0);
      chk("glitch_busy_a", 32'(busy_a), 32'h1);
      chk("glitch_allrel_a", 32'(allrel_a), 32'h0);
      chk("glitch_ch_b", 32'(ch_b), 32'h0);
      rst_n = 1'b1;
      run_to(4);
      chk("re_b_e4", 32'(ch_b), 32'h1);
      run_to(17);
      chk("re_e17", 32'(ch_a), 32'h0);
      run_to(18);
      chk("re_e18", 32'(ch_a), 32'h1);
      run_to(42);
      chk("re_e42", 32'(ch_a), 32'hF);
      chk("re_e42_busy", 32'(busy_a), 32'h0);
      run_to(50);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
